// File: rtl/pixel_fetch_pkg.sv
// pixel_fetch_pkg
// Shared constants and types for the pixel fetch stage and its neighbours.
//   MB_PIXELS / PIX_W  : macroblock size and pixel width
//   DEF_IMG_W/H        : default frame geometry, shared with the address generator
//   pix_beat_t         : one output beat (pixel, unclamped x/y, macroblock-last tag)
//   clampCoord         : saturate a coordinate to the last valid row/column
package pixel_fetch_pkg;

    localparam int MB_PIXELS = 256;
    localparam int PIX_W     = 8;
    localparam int COORD_W   = 32;
    localparam int DEF_IMG_W = 176;
    localparam int DEF_IMG_H = 144;

    typedef struct packed {
        logic [PIX_W-1:0]   pix;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               mb_last;
    } pix_beat_t;

    // Out-of-frame coordinates snap to the edge so the edge pixel is replicated.
    function automatic logic [COORD_W-1:0] clampCoord(input logic [COORD_W-1:0] c,
                                                      input int unsigned limit);
        return (c > COORD_W'(limit - 1)) ? COORD_W'(limit - 1) : c;
    endfunction

endpackage

// File: rtl/pixel_fetch_if.sv
// pixel_fetch_if
// Bundles the three streams around the pixel fetch stage.
//   start                       : synchronous frame restart from upstream
//   in_valid/in_ready/x_in/y_in : coordinate stream from the address generator
//   mem_rd_en/mem_addr/mem_rdata: synchronous frame-RAM read port (1-cycle data)
//   out_valid/out_ready/pix_out/x_out/y_out/mb_last : pixel beat stream downstream
// master = the fetch stage, slave = everything around it.
interface pixel_fetch_if
    import pixel_fetch_pkg::*;
    #(parameter int ADDR_W = 15) ();

    logic               start;
    logic               in_valid;
    logic               in_ready;
    logic [COORD_W-1:0] x_in;
    logic [COORD_W-1:0] y_in;
    logic               mem_rd_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIX_W-1:0]   mem_rdata;
    logic               out_valid;
    logic               out_ready;
    logic [PIX_W-1:0]   pix_out;
    logic [COORD_W-1:0] x_out;
    logic [COORD_W-1:0] y_out;
    logic               mb_last;

    modport master (
        input  start, in_valid, x_in, y_in, mem_rdata, out_ready,
        output in_ready, mem_rd_en, mem_addr, out_valid, pix_out, x_out, y_out, mb_last
    );

    modport slave (
        output start, in_valid, x_in, y_in, mem_rdata, out_ready,
        input  in_ready, mem_rd_en, mem_addr, out_valid, pix_out, x_out, y_out, mb_last
    );

endinterface

// File: rtl/pixel_fetch_sync_fifo.sv
// sync_fifo
// Single-clock FIFO with occupancy outputs, reusable by later pipeline stages.
//   clk, rst (async, active-low)
//   i_clear : synchronous flush, wins over push and pop
//   i_push/i_wdata, i_pop/o_rdata (head entry, combinational)
//   o_count, o_full, o_empty
module sync_fifo
    import pixel_fetch_pkg::*;
    #(
        parameter int WIDTH = $bits(pix_beat_t),
        parameter int DEPTH = 4,
        localparam int CNT_W = $clog2(DEPTH + 1),
        localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
    ) (
        input  logic             clk,
        input  logic             rst,
        input  logic             i_clear,
        input  logic             i_push,
        input  logic [WIDTH-1:0] i_wdata,
        input  logic             i_pop,
        output logic [WIDTH-1:0] o_rdata,
        output logic [CNT_W-1:0] o_count,
        output logic             o_full,
        output logic             o_empty
    );

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic             w_doPush;
    logic             w_doPop;

    // Depth need not be a power of two, so pointers wrap explicitly.
    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_empty  = (r_count == '0);
    assign o_full   = (r_count == CNT_W'(DEPTH));
    assign o_count  = r_count;
    assign o_rdata  = r_mem[r_rdPtr];
    assign w_doPop  = i_pop && !o_empty;
    // A push into a full FIFO is still fine when the head leaves in the same cycle.
    assign w_doPush = i_push && (!o_full || w_doPop);

    // Storage has no reset; the empty flag hides stale contents.
    always_ff @(posedge clk) begin
        if (w_doPush && !i_clear) begin
            r_mem[r_wrPtr] <= i_wdata;
        end
    end

    // Pointer and occupancy bookkeeping; a clear drops everything at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) r_wrPtr <= nextPtr(r_wrPtr);
            if (w_doPop)  r_rdPtr <= nextPtr(r_rdPtr);
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pixel_fetch.sv
// pixel_fetch
// Turns (x, y) coordinates into clamped linear frame-RAM reads and returns each
// pixel with its unclamped coordinates, buffered so backpressure never drops data.
//   clk, rst (async, active-low)
//   bus : pixel_fetch_if.master (start, coordinate in, RAM read port, beat out)
// Pipeline: accept (t) -> RAM read issued (t+1) -> FIFO write (t+2) -> out_valid (t+3).
module pixel_fetch
    import pixel_fetch_pkg::*;
    #(
        parameter int IMG_W      = DEF_IMG_W,
        parameter int IMG_H      = DEF_IMG_H,
        parameter int ADDR_W     = 15,
        parameter int FIFO_DEPTH = 4
    ) (
        input  logic          clk,
        input  logic          rst,
        pixel_fetch_if.master bus
    );

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic               r_alive;
    logic               r_rdEn;
    logic [ADDR_W-1:0]  r_addr;
    logic [COORD_W-1:0] r_x1;
    logic [COORD_W-1:0] r_y1;
    logic               r_last1;
    logic               r_wrValid;
    logic [COORD_W-1:0] r_x2;
    logic [COORD_W-1:0] r_y2;
    logic               r_last2;
    logic [7:0]         r_beatCnt;

    logic [COORD_W-1:0] w_xc;
    logic [COORD_W-1:0] w_yc;
    logic [1:0]         w_inflight;
    logic [CNT_W:0]     w_occupancy;
    logic               w_inReady;
    logic               w_accept;
    logic               w_pop;
    logic [CNT_W-1:0]   w_fifoCount;
    logic               w_fifoFull;
    logic               w_fifoEmpty;
    pix_beat_t          w_wdata;
    pix_beat_t          w_head;
    pix_beat_t          w_shown;

    assign w_xc = clampCoord(bus.x_in, IMG_W);
    assign w_yc = clampCoord(bus.y_in, IMG_H);

    // Reads issued or waiting on RAM data still need a FIFO slot reserved, which
    // keeps the FIFO from overflowing without looking at out_ready.
    assign w_inflight  = {1'b0, r_rdEn} + {1'b0, r_wrValid};
    assign w_occupancy = {1'b0, w_fifoCount} + (CNT_W + 1)'(w_inflight);
    assign w_inReady   = r_alive && !bus.start && !w_fifoFull &&
                         (w_occupancy < (CNT_W + 1)'(FIFO_DEPTH));
    assign w_accept    = bus.in_valid && w_inReady;
    assign w_pop       = !w_fifoEmpty && bus.out_ready;

    assign bus.in_ready  = w_inReady;
    assign bus.mem_rd_en = r_rdEn;
    assign bus.mem_addr  = r_addr;

    // RAM data lands one cycle after the strobe and is joined with the side-band
    // coordinates that travelled alongside the read.
    always_comb begin
        w_wdata         = '0;
        w_wdata.pix     = bus.mem_rdata;
        w_wdata.x       = r_x2;
        w_wdata.y       = r_y2;
        w_wdata.mb_last = r_last2;
    end

    sync_fifo #(
        .WIDTH ($bits(pix_beat_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_clear (bus.start),
        .i_push  (r_wrValid),
        .i_wdata (w_wdata),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_count (w_fifoCount),
        .o_full  (w_fifoFull),
        .o_empty (w_fifoEmpty)
    );

    // Outputs read as zero while nothing is buffered rather than showing stale RAM.
    always_comb begin
        w_shown = '0;
        if (!w_fifoEmpty) begin
            w_shown = w_head;
        end
    end

    assign bus.out_valid = !w_fifoEmpty;
    assign bus.pix_out   = w_shown.pix;
    assign bus.x_out     = w_shown.x;
    assign bus.y_out     = w_shown.y;
    assign bus.mb_last   = w_shown.mb_last;

    // Two-stage read pipeline plus the macroblock beat counter. A start discards
    // everything in flight; the RAM data for those reads is never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_alive   <= 1'b0;
            r_rdEn    <= 1'b0;
            r_addr    <= '0;
            r_x1      <= '0;
            r_y1      <= '0;
            r_last1   <= 1'b0;
            r_wrValid <= 1'b0;
            r_x2      <= '0;
            r_y2      <= '0;
            r_last2   <= 1'b0;
            r_beatCnt <= '0;
        end else begin
            r_alive <= 1'b1;
            if (bus.start) begin
                r_rdEn    <= 1'b0;
                r_wrValid <= 1'b0;
                r_beatCnt <= '0;
            end else begin
                r_rdEn    <= w_accept;
                r_wrValid <= r_rdEn;
                r_x2      <= r_x1;
                r_y2      <= r_y1;
                r_last2   <= r_last1;
                if (w_accept) begin
                    r_addr    <= ADDR_W'(w_yc * COORD_W'(IMG_W) + w_xc);
                    r_x1      <= bus.x_in;
                    r_y1      <= bus.y_in;
                    r_last1   <= (r_beatCnt == 8'(MB_PIXELS - 1));
                    r_beatCnt <= r_beatCnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_pixel_fetch.sv
// tb_pixel_fetch
// Scoreboard bench for pixel_fetch: accepted coordinates push an expected beat
// and an expected RAM address; reads and output beats pop and compare.
module tb_pixel_fetch;
    import pixel_fetch_pkg::*;

    localparam int IMG_W      = 176;
    localparam int IMG_H      = 144;
    localparam int ADDR_W     = 15;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        pix_beat_t beat;
        int        accCycle;
    } expEntry_t;

    logic clk = 1'b0;
    logic rst;
    logic [7:0] ramData = 8'h00;

    int checkCount = 0;
    int failCount  = 0;
    int cycle      = 0;
    bit latCheck   = 0;
    int beatsSeen  = 0;
    logic [7:0] tbBeatCnt = 8'h00;
    bit stallPrev = 0;
    logic [72:0] stallBeat;

    expEntry_t         expQ[$];
    logic [ADDR_W-1:0] addrQ[$];
    int                mbPos[$];

    pixel_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    pixel_fetch #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cycle++;

    // Synchronous frame RAM holding RAM[a] = a[7:0].
    always @(posedge clk) begin
        if (bus.mem_rd_en) ramData <= bus.mem_addr[7:0];
    end
    assign bus.mem_rdata = ramData;

    task automatic checkOutput(input string tag, input logic [95:0] observed,
                               input logic [95:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    function automatic logic [ADDR_W-1:0] modelAddr(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] xc;
        logic [31:0] yc;
        logic [31:0] lin;
        xc  = (x > 32'(IMG_W - 1)) ? 32'(IMG_W - 1) : x;
        yc  = (y > 32'(IMG_H - 1)) ? 32'(IMG_H - 1) : y;
        lin = yc * 32'(IMG_W) + xc;
        return lin[ADDR_W-1:0];
    endfunction

    // Monitor sampling on the falling edge, halfway between active edges.
    always @(negedge clk) begin
        logic [ADDR_W-1:0] a;
        expEntry_t e;
        if (!rst) begin
            expQ.delete();
            addrQ.delete();
            tbBeatCnt = 8'h00;
            stallPrev = 0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                a = modelAddr(bus.x_in, bus.y_in);
                e.beat.pix     = a[7:0];
                e.beat.x       = bus.x_in;
                e.beat.y       = bus.y_in;
                e.beat.mb_last = (tbBeatCnt == 8'd255);
                e.accCycle     = cycle;
                expQ.push_back(e);
                addrQ.push_back(a);
                tbBeatCnt = tbBeatCnt + 8'd1;
            end
            if (bus.mem_rd_en) begin
                if (addrQ.size() == 0) checkOutput("spurious_read", 1, 0);
                else checkOutput("mem_addr", 96'(bus.mem_addr), 96'(addrQ.pop_front()));
            end
            if (bus.out_valid && !bus.out_ready) begin
                if (stallPrev)
                    checkOutput("stall_stable", {bus.pix_out, bus.x_out, bus.y_out, bus.mb_last}, stallBeat);
                stallPrev = 1;
                stallBeat = {bus.pix_out, bus.x_out, bus.y_out, bus.mb_last};
            end else begin
                stallPrev = 0;
            end
            if (bus.out_valid && bus.out_ready) begin
                beatsSeen++;
                if (bus.mb_last) mbPos.push_back(beatsSeen);
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_beat", 1, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("pix_out", 96'(bus.pix_out), 96'(e.beat.pix));
                    checkOutput("x_out", 96'(bus.x_out), 96'(e.beat.x));
                    checkOutput("y_out", 96'(bus.y_out), 96'(e.beat.y));
                    checkOutput("mb_last", 96'(bus.mb_last), 96'(e.beat.mb_last));
                    if (latCheck) checkOutput("latency", 96'(cycle - e.accCycle), 3);
                end
            end
            if (bus.start) begin
                expQ.delete();
                addrQ.delete();
                tbBeatCnt = 8'h00;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the coordinate was taken.
    task automatic applyStimulus(input logic [31:0] x, input logic [31:0] y);
        int budget = 200;
        bus.in_valid = 1'b1;
        bus.x_in     = x;
        bus.y_in     = y;
        @(negedge clk);
        while (!(bus.in_ready && rst) && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        if (budget == 0) checkOutput("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input string tag);
        int budget = 300;
        while (expQ.size() != 0 && budget > 0) begin
            @(posedge clk);
            #1;
            budget--;
        end
        checkOutput({tag, "_drain"}, 96'(expQ.size()), 0);
    endtask

    task automatic pulseStart();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_out_valid"}, 96'(bus.out_valid), 0);
        checkOutput({tag, "_in_ready"}, 96'(bus.in_ready), 0);
        checkOutput({tag, "_mem_rd_en"}, 96'(bus.mem_rd_en), 0);
        checkOutput({tag, "_mem_addr"}, 96'(bus.mem_addr), 0);
        checkOutput({tag, "_pix_out"}, 96'(bus.pix_out), 0);
        checkOutput({tag, "_x_out"}, 96'(bus.x_out), 0);
        checkOutput({tag, "_y_out"}, 96'(bus.y_out), 0);
        checkOutput({tag, "_mb_last"}, 96'(bus.mb_last), 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst           = 1'b0;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x_in      = '0;
        bus.y_in      = '0;
        bus.out_ready = 1'b1;

        #2;
        checkAllZero("reset");
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", 96'(bus.in_ready), 1);

        $display("[TB] basic stream");
        latCheck = 1;
        applyStimulus(0, 0);
        applyStimulus(1, 0);
        applyStimulus(2, 0);
        waitDrain("basic");
        latCheck = 0;

        $display("[TB] edge clamping");
        applyStimulus(200, 10);
        applyStimulus(5, 150);
        applyStimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 16; i++)
            applyStimulus($urandom_range(0, 300), $urandom_range(0, 200));
        waitDrain("clamp");

        $display("[TB] backpressure");
        fork
            begin
                for (int i = 0; i < 24; i++) applyStimulus(i * 3, i);
            end
            begin
                bus.out_ready = 1'b0;
                repeat (8) @(negedge clk);
                checkOutput("in_ready_stalled", 96'(bus.in_ready), 0);
                repeat (2) @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        waitDrain("backpressure");

        $display("[TB] two macroblocks");
        pulseStart();
        beatsSeen = 0;
        mbPos.delete();
        for (int i = 0; i < 512; i++) applyStimulus((i % 16) + 16 * (i / 256), (i % 256) / 16);
        waitDrain("mb");
        checkOutput("mb_last_count", 96'(mbPos.size()), 2);
        if (mbPos.size() == 2) begin
            checkOutput("mb_last_pos0", 96'(mbPos[0]), 256);
            checkOutput("mb_last_pos1", 96'(mbPos[1]), 512);
        end

        $display("[TB] start flush");
        bus.out_ready = 1'b0;
        applyStimulus(10, 1);
        applyStimulus(11, 1);
        waitCycles(2);
        applyStimulus(12, 1);
        applyStimulus(13, 1);
        checkOutput("pre_start_out_valid", 96'(bus.out_valid), 1);
        checkOutput("pre_start_rd_en", 96'(bus.mem_rd_en), 1);
        bus.start = 1'b1;
        #1;
        checkOutput("start_in_ready", 96'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        checkOutput("post_start_out_valid", 96'(bus.out_valid), 0);
        checkOutput("post_start_rd_en", 96'(bus.mem_rd_en), 0);
        bus.out_ready = 1'b1;
        waitCycles(6);
        checkOutput("post_start_idle", 96'(bus.out_valid), 0);
        beatsSeen = 0;
        mbPos.delete();
        for (int i = 0; i < 256; i++) applyStimulus(i % 16, i / 16);
        waitDrain("restart");
        checkOutput("restart_mb_count", 96'(mbPos.size()), 1);
        if (mbPos.size() == 1) checkOutput("restart_mb_pos", 96'(mbPos[0]), 256);

        $display("[TB] async reset mid-stream");
        fork
            begin
                for (int i = 0; i < 12; i++) applyStimulus(i, 100 + i);
            end
            begin
                repeat (5) @(posedge clk);
                #3 rst = 1'b0;
                #1;
                checkAllZero("async_reset");
                #9 rst = 1'b1;
                @(posedge clk);
                @(negedge clk);
                checkOutput("in_ready_after_release", 96'(bus.in_ready), 1);
            end
        join
        waitDrain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
